// File: rtl/uart_prog_ctrl.sv
// uart_prog_ctrl: parses a UART download frame (TGT, CNT LE, N LE words) and
// drives the shared upg_* instruction/data memory write port.
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   prog_req_i    pulse: start (or restart) a programming session
//   rx_valid_i    strobe: rx_byte_i holds a received byte
//   rx_byte_i     received byte
//   upg_rst_o     1 = CPU-run mode (no session since reset)
//   upg_wen_o     one-cycle memory write strobe
//   upg_adr_o     {target, word index[13:0]}
//   upg_dat_o     assembled write word
//   upg_done_o    last session completed OK
//   busy_o        session in progress
//   err_o         last session aborted (bad header or timeout)
module uart_prog_ctrl #(
  parameter logic [23:0] TIMEOUT_CYC = 24'd1_000_000,
  parameter int unsigned MAX_WORDS   = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        prog_req_i,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_byte_i,
  output logic        upg_rst_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_TGT, S_CNT0, S_CNT1, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        tgt_q, tgt_d;
  logic [15:0] cnt_q, cnt_d;
  logic [14:0] idx_q, idx_d;
  logic [1:0]  bsel_q, bsel_d;
  logic [23:0] word_q, word_d;
  logic [23:0] tmo_q, tmo_d;
  logic        rst_d, wen_d, done_d, busy_d, err_d;
  logic [14:0] adr_d;
  logic [31:0] dat_d;
  logic [15:0] cnt_full;

  assign cnt_full = {rx_byte_i, cnt_q[7:0]};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tgt_q      <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      bsel_q     <= '0;
      word_q     <= '0;
      tmo_q      <= '0;
      upg_rst_o  <= 1'b1;
      upg_wen_o  <= 1'b0;
      upg_adr_o  <= '0;
      upg_dat_o  <= '0;
      upg_done_o <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      bsel_q     <= bsel_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      upg_rst_o  <= rst_d;
      upg_wen_o  <= wen_d;
      upg_adr_o  <= adr_d;
      upg_dat_o  <= dat_d;
      upg_done_o <= done_d;
      busy_o     <= busy_d;
      err_o      <= err_d;
    end
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bsel_d  = bsel_q;
    word_d  = word_q;
    tmo_d   = tmo_q;
    wen_d   = 1'b0;
    adr_d   = upg_adr_o;
    dat_d   = upg_dat_o;

    case (state_q)
      S_TGT: if (rx_valid_i) begin
        if (rx_byte_i > 8'd1) state_d = S_ERR;
        else begin
          tgt_d   = rx_byte_i[0];
          state_d = S_CNT0;
        end
      end
      S_CNT0: if (rx_valid_i) begin
        cnt_d[7:0] = rx_byte_i;
        state_d    = S_CNT1;
      end
      S_CNT1: if (rx_valid_i) begin
        cnt_d[15:8] = rx_byte_i;
        if (cnt_full == 16'd0) state_d = S_DONE;
        else if (32'(cnt_full) > MAX_WORDS) state_d = S_ERR;
        else begin
          idx_d   = '0;
          bsel_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: if (rx_valid_i) begin
        bsel_d = bsel_q + 2'd1;
        case (bsel_q)
          2'd0: word_d[7:0]   = rx_byte_i;
          2'd1: word_d[15:8]  = rx_byte_i;
          2'd2: word_d[23:16] = rx_byte_i;
          default: begin
            dat_d   = {rx_byte_i, word_q};
            adr_d   = {tgt_q, idx_q[13:0]};
            wen_d   = 1'b1;
            state_d = S_WRITE;
          end
        endcase
      end
      S_WRITE: begin
        idx_d = idx_q + 15'd1;
        if (({1'b0, idx_q} + 16'd1) == cnt_q) state_d = S_DONE;
        else begin
          state_d = S_DATA;
          // A byte landing during the write slot starts the next word
          if (rx_valid_i) begin
            word_d[7:0] = rx_byte_i;
            bsel_d      = 2'd1;
          end
        end
      end
      default: ;
    endcase

    // Inter-byte timeout inside a frame; a received byte restarts the count
    if (state_q inside {S_TGT, S_CNT0, S_CNT1, S_DATA}) begin
      if (rx_valid_i) tmo_d = '0;
      else if ((tmo_q + 24'd1) == TIMEOUT_CYC) begin
        tmo_d   = '0;
        state_d = S_ERR;
      end else tmo_d = tmo_q + 24'd1;
    end else begin
      tmo_d = '0;
    end

    // A new request always wins and abandons any partial word
    if (prog_req_i) begin
      state_d = S_TGT;
      tmo_d   = '0;
      wen_d   = 1'b0;
      adr_d   = upg_adr_o;
      dat_d   = upg_dat_o;
    end

    rst_d  = (state_d == S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
  end

endmodule

// File: tb/tb_uart_prog_ctrl.sv
// Self-checking bench for uart_prog_ctrl: expected writes are queued as
// stimulus is driven and popped whenever the DUT strobes upg_wen_o.
module tb_uart_prog_ctrl;

  localparam logic [23:0] TMO = 24'd300;

  logic        clk = 1'b0;
  logic        rst, prog_req, rx_valid;
  logic [7:0]  rx_byte;
  logic        upg_rst, upg_wen, upg_done, busy, err;
  logic [14:0] upg_adr;
  logic [31:0] upg_dat;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes = 0;
  logic [46:0] exp_q[$];

  always #5 clk = ~clk;

  uart_prog_ctrl #(.TIMEOUT_CYC(TMO), .MAX_WORDS(16384)) dut (
    .clk(clk), .rst(rst), .prog_req_i(prog_req), .rx_valid_i(rx_valid),
    .rx_byte_i(rx_byte), .upg_rst_o(upg_rst), .upg_wen_o(upg_wen),
    .upg_adr_o(upg_adr), .upg_dat_o(upg_dat), .upg_done_o(upg_done),
    .busy_o(busy), .err_o(err)
  );

  // Advance one cycle, sample after the edge and score any write strobe
  task automatic tick();
    logic [46:0] e;
    @(posedge clk); #1;
    if (upg_wen === 1'b1) begin
      n_writes++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_wen: got adr=%h dat=%h, expected no write", upg_adr, upg_dat);
      end else begin
        e = exp_q.pop_front();
        if ({upg_adr, upg_dat} !== e) begin
          n_fail++;
          $display("FAIL write_data: got adr=%h dat=%h, expected adr=%h dat=%h",
                   upg_adr, upg_dat, e[46:32], e[31:0]);
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic pulse_prog();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
  endtask

  // Queue the expected write, then send the word little-endian
  task automatic send_word(input logic tgt, input logic [13:0] idx,
                           input logic [31:0] w, input int gap);
    exp_q.push_back({tgt, idx, w});
    for (int i = 0; i < 4; i++) begin
      rx_valid = 1'b1;
      rx_byte  = w[8*i +: 8];
      tick();
      rx_valid = 1'b0;
      if (i == 3) begin
        n_tests++;
        if (upg_wen !== 1'b1) begin
          n_fail++;
          $display("FAIL wen_latency: got wen=%b, expected 1", upg_wen);
        end
      end
      repeat (gap) tick();
    end
  endtask

  task automatic check_status(input string name, input logic [3:0] exp);
    n_tests++;
    if ({upg_rst, upg_done, busy, err} !== exp) begin
      n_fail++;
      $display("FAIL %s: got {rst,done,busy,err}=%b, expected %b",
               name, {upg_rst, upg_done, busy, err}, exp);
    end
  endtask

  task automatic check_drained(input string name, input int w0, input int nexp);
    n_tests++;
    if (exp_q.size() != 0 || (n_writes - w0) != nexp) begin
      n_fail++;
      $display("FAIL %s: got %0d writes with %0d pending, expected %0d writes with 0 pending",
               name, n_writes - w0, exp_q.size(), nexp);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_req = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_tests++;
    if ({upg_rst, upg_wen, upg_adr, upg_dat, upg_done, busy, err} !== {1'b1, 1'b0, 15'd0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_values: got rst=%b wen=%b adr=%h dat=%h done=%b busy=%b err=%b, expected 1 0 0000 00000000 0 0 0",
               upg_rst, upg_wen, upg_adr, upg_dat, upg_done, busy, err);
    end
    send_byte(8'h00, 1);
    check_status("rx_ignored_idle", 4'b1000);
  endtask

  task automatic test_two_words();
    int w0 = n_writes;
    pulse_prog();
    check_status("prog_enter", 4'b0010);
    send_byte(8'h00, 2); send_byte(8'h02, 1); send_byte(8'h00, 2);
    send_word(1'b0, 14'd0, 32'h2000_0013, 2);
    send_word(1'b0, 14'd1, 32'h0800_FFFF, 0);
    repeat (2) tick();
    check_status("two_words_done", 4'b0100);
    check_drained("two_words_writes", w0, 2);
  endtask

  task automatic test_back_to_back();
    int w0 = n_writes;
    pulse_prog();
    send_byte(8'h01, 0); send_byte(8'h03, 0); send_byte(8'h00, 0);
    send_word(1'b1, 14'd0, 32'h1234_5678, 0);
    send_word(1'b1, 14'd1, 32'hA5A5_0F0F, 0);
    send_word(1'b1, 14'd2, 32'hDEAD_BEEF, 0);
    repeat (2) tick();
    check_status("b2b_done", 4'b0100);
    check_drained("b2b_writes", w0, 3);
  endtask

  task automatic test_bad_tgt();
    int w0 = n_writes;
    pulse_prog();
    send_byte(8'h05, 1);
    check_status("bad_tgt_err", 4'b0001);
    pulse_prog();
    check_status("err_cleared", 4'b0010);
    send_byte(8'h01, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(1'b1, 14'd0, 32'hCAFE_F00D, 1);
    tick();
    check_status("after_err_done", 4'b0100);
    check_drained("bad_tgt_writes", w0, 1);
  endtask

  task automatic test_timeout();
    int w0 = n_writes;
    pulse_prog();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    repeat (int'(TMO) - 1) tick();
    check_status("timeout_edge_minus1", 4'b0010);
    tick();
    check_status("timeout_err", 4'b0001);
    send_byte(8'hCC, 0); send_byte(8'hDD, 3);
    check_status("rx_ignored_err", 4'b0001);
    check_drained("timeout_writes", w0, 0);
  endtask

  task automatic test_count_limits();
    int w0 = n_writes;
    pulse_prog();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 1);
    check_status("zero_count_done", 4'b0100);
    pulse_prog();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h40, 1);
    check_status("over_max_err", 4'b0001);
    pulse_prog();
    send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h40, 1);
    check_status("max_count_busy", 4'b0010);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    pulse_prog();
    check_status("restart_busy", 4'b0010);
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(1'b0, 14'd0, 32'h0102_0304, 1);
    tick();
    check_status("restart_done", 4'b0100);
    check_drained("limits_writes", w0, 1);
  endtask

  task automatic test_reset_mid_frame();
    int w0 = n_writes;
    pulse_prog();
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_word(1'b1, 14'd0, 32'h5566_7788, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({upg_rst, upg_wen, upg_adr, upg_dat, upg_done, busy, err} !== {1'b1, 1'b0, 15'd0, 32'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got rst=%b wen=%b adr=%h dat=%h done=%b busy=%b err=%b, expected 1 0 0000 00000000 0 0 0",
               upg_rst, upg_wen, upg_adr, upg_dat, upg_done, busy, err);
    end
    send_byte(8'hCC, 0); send_byte(8'hDD, 2);
    check_status("after_reset_idle", 4'b1000);
    pulse_prog();
    send_byte(8'h00, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_word(1'b0, 14'd0, 32'h0BAD_F00D, 1);
    tick();
    check_status("after_reset_done", 4'b0100);
    check_drained("reset_mid_writes", w0, 2);
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_back_to_back();
    test_bad_tgt();
    test_timeout();
    test_count_limits();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
